systolic_feeder: RTL
====================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter BITS, default 8: signed element width.
REQ-002 SHALL have parameter DIM, default 8: matrix dimension and lane count.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load_en  input  1  write load_data into buffer row load_row.
REQ-006 SHALL have port load_row  input  $clog2(DIM)  buffer row index for the write.
REQ-007 SHALL have port load_data  input  DIM x BITS signed  one matrix row; element c goes to column c.
REQ-008 SHALL have port start  input  1  begin a skewed feed sequence.
REQ-009 SHALL have port vec_out  output  DIM x BITS signed  skewed lane vector for the array's A or B inputs.
REQ-010 SHALL have port vec_valid  output  1  high while vec_out carries FEED data.
REQ-011 SHALL have port busy  output  1  high in FEED and DRAIN; the array's en connects here.
REQ-012 SHALL have port done  output  1  one-cycle pulse on sequence completion.

Function
REQ-013 SHALL hold a DIM x DIM signed buffer M of BITS-wide elements.
REQ-014 SHALL implement states IDLE, FEED and DRAIN.
REQ-015 IDLE->FEED SHALL occur on a clock edge with start=1; FEED->DRAIN after exactly 2*DIM-1 FEED cycles; DRAIN->IDLE after exactly DIM DRAIN cycles.
REQ-016 During FEED step t (t=0..2*DIM-2, the t-th FEED cycle), lane i SHALL equal M[i][t-i] when 0<=t-i<DIM, else 0.
REQ-017 vec_out SHALL be registered: step 0 appears in the first cycle after the edge that sampled start.
REQ-018 In IDLE and DRAIN, vec_out SHALL be all zeros and vec_valid SHALL be 0.
REQ-019 busy SHALL be 1 exactly when the state is FEED or DRAIN.
REQ-020 done SHALL be 1 for exactly one cycle: the first IDLE cycle after DRAIN.
REQ-021 load_en SHALL write M[load_row] only in IDLE; it SHALL be ignored in FEED and DRAIN.
REQ-022 start SHALL be ignored while busy=1; no queuing.
REQ-023 If load_en and start are both 1 on the same IDLE edge, the write SHALL commit on that edge and FEED SHALL use the updated row.
REQ-024 If start is held high continuously, a new sequence SHALL begin on the done cycle's edge; done and the next step 0 are not simultaneous.
REQ-025 Skew counter width SHALL cover 0..2*DIM-2, with no wrap during FEED.
REQ-026 Data SHALL pass unmodified, with no arithmetic or saturation.

Reset
REQ-027 On an edge with rst=1: state SHALL be IDLE, all M elements 0, vec_out 0, and vec_valid, busy and done 0.
REQ-028 rst during FEED or DRAIN SHALL abort the sequence with no done pulse; the first post-reset cycle is IDLE with all outputs 0.
REQ-029 rst SHALL override load_en and start on the same edge.

Structure
REQ-030 The state enum type (feed_state_t) SHALL reside in shared package systolic_pkg.
REQ-031 The BITS and DIM default constants SHALL reside in systolic_pkg, shared with the systolic array.
REQ-032 SHALL be a single module with no sub-module.
REQ-033 Two instances (A feeder, B feeder loaded with B transposed) SHALL feed the array directly.

Verification (DIM=8, M[r][c]=16r+c+1)
REQ-034 SHALL load all rows, pulse start -> step 0: lane0=1, lanes1-7=0; step 3: lanes0-3 = 4,19,34,49, lanes4-7 = 0.
REQ-035 SHALL check step 14 -> lane7=120, lanes0-6=0; vec_valid high 15 cycles, busy high 23 cycles, done pulse in cycle 24.
REQ-036 SHALL hold start high -> back-to-back sequences, each with one done pulse, each step 0 identical.
REQ-037 SHALL apply load_en row2=all 0x7F during FEED -> ignored, so a second sequence step 2 gives lane2=M[2][0]=33.
REQ-038 SHALL assert rst at FEED step 5 -> next cycle IDLE, all outputs 0, no done; a subsequent start outputs all-zero lanes.
REQ-039 SHALL apply load_en row0=all -1 together with start -> step 0 lane0=-1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its operand feeders:
// default element width / dimension and the feeder sequencing states.
package systolic_pkg;

    localparam int BITS_DEFAULT = 8;
    localparam int DIM_DEFAULT  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } feed_state_t;

    // Width of a counter that must reach 2*dim-2 without wrapping (at least 1 bit).
    function automatic int step_cnt_width(input int dim);
        int w;
        w = $clog2(2 * dim - 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/systolic_feeder.sv
// Holds a DIM x DIM operand matrix and streams it into a systolic array edge
// as a diagonally skewed lane vector: FEED for 2*DIM-1 cycles, then DRAIN for DIM.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT,
    parameter int DIM  = DIM_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_en,
    input  logic [$clog2(DIM)-1:0]           load_row,
    input  logic [DIM-1:0][BITS-1:0]         load_data,
    input  logic                             start,
    output logic [DIM-1:0][BITS-1:0]         vec_out,
    output logic                             vec_valid,
    output logic                             busy,
    output logic                             done,
    output feed_state_t                      state_dbg
);

    localparam int CW = step_cnt_width(DIM);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * DIM - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DIM - 1);

    feed_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DIM-1:0][DIM-1:0][BITS-1:0] m_q, m_d;
    logic [DIM-1:0][BITS-1:0] vec_q, vec_d;
    logic done_q, done_d;

    logic [CW-1:0] skew_t;
    logic [DIM-1:0][BITS-1:0] skew_vec;

    // Writes are only honoured in IDLE; a write on the start edge feeds step 0 directly.
    always_comb begin
        m_d = m_q;
        if (state_q == ST_IDLE && load_en && int'(load_row) < DIM) begin
            m_d[load_row] = load_data;
        end
    end

    // Lane i at step t carries M[i][t-i]; lanes outside the diagonal band are zero.
    always_comb begin
        skew_vec = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int c = 0; c < DIM; c++) begin
                if (int'(skew_t) == i + c) begin
                    skew_vec[i] = m_d[i][c];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        vec_d   = '0;
        skew_t  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FEED;
                    cnt_d   = '0;
                    skew_t  = '0;
                    vec_d   = skew_vec;
                end
            end
            ST_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    skew_t = cnt_q + CW'(1);
                    vec_d  = skew_vec;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            vec_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            vec_q   <= vec_d;
            done_q  <= done_d;
        end
    end

    // No backpressure: vec_valid qualifies vec_out every cycle and the array must accept it.
    assign vec_out   = vec_q;
    assign vec_valid = (state_q == ST_FEED);
    assign busy      = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
